dbi_tx_fsm: RTL and testbench

//  Upstream sequencer for the DBI PHY. Accepts command requests (reset, command-only, command+params,

---
 rtl/dbi_tx_fsm_pkg.sv | 18 +
 rtl/dbi_tx_fsm_if.sv | 48 ++++
 rtl/dbi_tx_fsm.sv | 165 ++++++++++++++++
 tb/tb_dbi_tx_fsm.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbi_tx_fsm_pkg.sv
// Shared definitions for the DBI transmit sequencer: FSM state encoding and common DBI opcodes.
package dbi_tx_fsm_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_HDR,
        ST_PRM,
        ST_PIX
    } state_e;

    localparam logic [7:0] OP_SLPOUT = 8'h11;
    localparam logic [7:0] OP_DISPON = 8'h29;
    localparam logic [7:0] OP_CASET  = 8'h2A;
    localparam logic [7:0] OP_PASET  = 8'h2B;
    localparam logic [7:0] OP_RAMWR  = 8'h2C;

endpackage

// File: rtl/dbi_tx_fsm_if.sv
// Request, parameter, pixel and PHY-beat streams of the DBI transmit sequencer.
interface dbi_tx_fsm_if #(
    parameter int unsigned W         = 8,
    parameter int unsigned PRM_CNT_W = 4
);
    logic                 req_vld_i;
    logic                 req_rdy_o;
    logic                 req_hrst_i;
    logic [W-1:0]         req_typ_i;
    logic                 req_pix_i;
    logic [PRM_CNT_W-1:0] req_prm_num_i;

    logic                 prm_vld_i;
    logic [W-1:0]         prm_dat_i;
    logic                 prm_rdy_o;

    logic                 pix_vld_i;
    logic [2*W-1:0]       pix_dat_i;
    logic                 pix_last_i;
    logic                 pix_rdy_o;

    logic                 dtf_dbi_hrst_o;
    logic [W-1:0]         dtf_tx_cmd_typ_o;
    logic [W-1:0]         dtf_tx_cmd_dat_o;
    logic                 dtf_tx_no_dat_o;
    logic                 dtf_tx_last_o;
    logic                 dtf_tx_vld_o;
    logic                 dtf_tx_rdy_i;

    modport slave (
        input  req_vld_i, req_hrst_i, req_typ_i, req_pix_i, req_prm_num_i,
        input  prm_vld_i, prm_dat_i, pix_vld_i, pix_dat_i, pix_last_i,
        input  dtf_tx_rdy_i,
        output req_rdy_o, prm_rdy_o, pix_rdy_o,
        output dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
        output dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
    );

    modport master (
        output req_vld_i, req_hrst_i, req_typ_i, req_pix_i, req_prm_num_i,
        output prm_vld_i, prm_dat_i, pix_vld_i, pix_dat_i, pix_last_i,
        output dtf_tx_rdy_i,
        input  req_rdy_o, prm_rdy_o, pix_rdy_o,
        input  dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
        input  dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
    );

endinterface

// File: rtl/dbi_tx_fsm.sv
// DBI PHY upstream sequencer: turns reset/command/parameter/pixel requests into PHY beats.
// Stream data passes straight through to the PHY; 16-bit pixels are split into two bytes.
module dbi_tx_fsm
    import dbi_tx_fsm_pkg::*;
#(
    parameter int unsigned DBI_IF_D_W    = 8,
    parameter int unsigned PRM_CNT_W     = 4,
    parameter bit          AUTO_HRST     = 1'b1,
    parameter bit          PIX_MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    dbi_tx_fsm_if.slave bus,
    output logic        busy_o,
    output logic        frm_done_o
);

    typedef logic [DBI_IF_D_W-1:0] byte_t;

    localparam state_e RST_STATE = AUTO_HRST ? ST_RST : ST_IDLE;

    state_e               state_q, state_d;
    byte_t                typ_q, typ_d;
    logic                 hrst_q, hrst_d;
    logic                 pix_q, pix_d;
    logic [PRM_CNT_W-1:0] rem_q, rem_d;
    logic                 bsel_q, bsel_d;
    logic                 done_q, done_d;
    logic                 run_q;

    logic  vld, hrst, no_dat, last;
    logic  req_rdy, prm_rdy, pix_rdy;
    logic  prm_beat;
    byte_t dat;

    function automatic byte_t pix_byte(input logic [2*DBI_IF_D_W-1:0] pix, input logic second);
        logic hi;
        hi = PIX_MSB_FIRST ^ second;
        return hi ? pix[2*DBI_IF_D_W-1:DBI_IF_D_W] : pix[DBI_IF_D_W-1:0];
    endfunction

    // run_q holds every output low while rst_n is asserted and for the release cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            typ_q   <= '0;
            hrst_q  <= 1'b0;
            pix_q   <= 1'b0;
            rem_q   <= '0;
            bsel_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            typ_q   <= typ_d;
            hrst_q  <= hrst_d;
            pix_q   <= pix_d;
            rem_q   <= rem_d;
            bsel_q  <= bsel_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        typ_d    = typ_q;
        hrst_d   = hrst_q;
        pix_d    = pix_q;
        rem_d    = rem_q;
        bsel_d   = bsel_q;
        done_d   = 1'b0;
        vld      = 1'b0;
        hrst     = 1'b0;
        dat      = '0;
        no_dat   = 1'b0;
        last     = 1'b0;
        req_rdy  = 1'b0;
        prm_rdy  = 1'b0;
        pix_rdy  = 1'b0;
        prm_beat = 1'b0;

        if (run_q) begin
            case (state_q)
                ST_RST: begin
                    vld  = 1'b1;
                    hrst = 1'b1;
                    if (bus.dtf_tx_rdy_i) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    req_rdy = 1'b1;
                    if (bus.req_vld_i) begin
                        hrst_d  = bus.req_hrst_i;
                        typ_d   = bus.req_hrst_i ? '0 : bus.req_typ_i;
                        pix_d   = bus.req_pix_i;
                        rem_d   = bus.req_prm_num_i;
                        bsel_d  = 1'b0;
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (hrst_q) begin
                        vld  = 1'b1;
                        hrst = 1'b1;
                        if (bus.dtf_tx_rdy_i) state_d = ST_IDLE;
                    end else if (pix_q) begin
                        vld = bus.pix_vld_i;
                        dat = pix_byte(bus.pix_dat_i, 1'b0);
                        if (vld && bus.dtf_tx_rdy_i) begin
                            bsel_d  = 1'b1;
                            state_d = ST_PIX;
                        end
                    end else if (rem_q == '0) begin
                        vld    = 1'b1;
                        no_dat = 1'b1;
                        last   = 1'b1;
                        if (bus.dtf_tx_rdy_i) state_d = ST_IDLE;
                    end else begin
                        prm_beat = 1'b1;
                    end
                end
                ST_PRM: prm_beat = 1'b1;
                ST_PIX: begin
                    vld     = bus.pix_vld_i;
                    dat     = pix_byte(bus.pix_dat_i, bsel_q);
                    pix_rdy = bus.dtf_tx_rdy_i & bsel_q;
                    last    = bus.pix_last_i & bsel_q;
                    if (vld && bus.dtf_tx_rdy_i) begin
                        bsel_d = ~bsel_q;
                        if (last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // The first parameter rides on the header beat; the rest follow in PRM
            if (prm_beat) begin
                vld     = bus.prm_vld_i;
                dat     = bus.prm_dat_i;
                prm_rdy = bus.dtf_tx_rdy_i;
                last    = (rem_q == PRM_CNT_W'(1));
                if (vld && bus.dtf_tx_rdy_i) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = last ? ST_IDLE : ST_PRM;
                end
            end
        end
    end

    assign bus.req_rdy_o        = req_rdy;
    assign bus.prm_rdy_o        = prm_rdy;
    assign bus.pix_rdy_o        = pix_rdy;
    assign bus.dtf_dbi_hrst_o   = hrst;
    assign bus.dtf_tx_cmd_typ_o = typ_q;
    assign bus.dtf_tx_cmd_dat_o = dat;
    assign bus.dtf_tx_no_dat_o  = no_dat;
    assign bus.dtf_tx_last_o    = last;
    assign bus.dtf_tx_vld_o     = vld;
    assign busy_o               = run_q & (state_q != ST_IDLE);
    assign frm_done_o           = done_q;

endmodule

// File: tb/tb_dbi_tx_fsm.sv
// Bench for dbi_tx_fsm: table of commands expanded into an expected beat queue, plus reset corner cases.
module tb_dbi_tx_fsm;
    import dbi_tx_fsm_pkg::*;

    typedef struct packed {
        logic        hrst;
        logic [7:0]  typ;
        logic        pix;
        logic [3:0]  num;
        logic [7:0]  npix;
        logic [3:0][15:0] data;
        logic [7:0]  exp_beats;
        logic [7:0]  exp_pix;
        logic [7:0]  exp_done;
    } vec_t;

    typedef struct packed {
        logic       hrst;
        logic [7:0] typ;
        logic [7:0] dat;
        logic       no_dat;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic       hrst;
        logic [7:0] typ;
        logic       pix;
        logic [3:0] num;
    } req_t;

    typedef struct packed {
        logic        last;
        logic [15:0] dat;
    } pix_t;

    logic clk;
    logic rst_n;
    logic busy;
    logic frm_done;

    dbi_tx_fsm_if #(.W(8), .PRM_CNT_W(4)) bus ();

    dbi_tx_fsm #(
        .DBI_IF_D_W   (8),
        .PRM_CNT_W    (4),
        .AUTO_HRST    (1'b1),
        .PIX_MSB_FIRST(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .frm_done_o(frm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    beat_cnt = 0;
    int    pix_cnt = 0;
    int    done_cnt = 0;
    bit    gap = 1'b0;
    logic  req_take = 1'b0;
    logic  prm_take = 1'b0;
    logic  pix_take = 1'b0;
    beat_t exp_q[$];
    req_t  req_q[$];
    logic [7:0] prm_q[$];
    pix_t  pix_q[$];
    vec_t  vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Negedge sampling: record handshakes and score PHY beats against the expected queue
    task automatic sample();
        beat_t e;
        req_take = bus.req_vld_i & bus.req_rdy_o;
        prm_take = bus.prm_vld_i & bus.prm_rdy_o;
        pix_take = bus.pix_vld_i & bus.pix_rdy_o;
        if (pix_take) pix_cnt++;
        if (frm_done) done_cnt++;
        if (bus.dtf_tx_vld_o && bus.dtf_tx_rdy_i) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got typ=%h dat=%h hrst=%b last=%b expected no beat",
                         bus.dtf_tx_cmd_typ_o, bus.dtf_tx_cmd_dat_o, bus.dtf_dbi_hrst_o, bus.dtf_tx_last_o);
            end else begin
                e = exp_q.pop_front();
                if (e.hrst)
                    chk("hrst_beat", {30'd0, busy, bus.dtf_dbi_hrst_o}, 32'd3);
                else
                    chk($sformatf("beat%0d", beat_cnt),
                        {12'd0, busy, bus.dtf_dbi_hrst_o, bus.dtf_tx_cmd_typ_o, bus.dtf_tx_cmd_dat_o,
                         bus.dtf_tx_no_dat_o, bus.dtf_tx_last_o},
                        {12'd0, 1'b1, e});
            end
        end
    endtask

    task automatic cycle();
        req_t r;
        pix_t p;
        @(posedge clk);
        #1;
        if (req_take && req_q.size() > 0) void'(req_q.pop_front());
        if (prm_take && prm_q.size() > 0) void'(prm_q.pop_front());
        if (pix_take && pix_q.size() > 0) void'(pix_q.pop_front());
        bus.dtf_tx_rdy_i = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (req_q.size() > 0) begin
            r = req_q[0];
            bus.req_vld_i     = 1'b1;
            bus.req_hrst_i    = r.hrst;
            bus.req_typ_i     = r.typ;
            bus.req_pix_i     = r.pix;
            bus.req_prm_num_i = r.num;
        end else begin
            bus.req_vld_i = 1'b0;
        end
        if (prm_q.size() > 0) begin
            bus.prm_dat_i = prm_q[0];
            bus.prm_vld_i = !gap || ($urandom_range(0, 2) != 0);
        end else begin
            bus.prm_vld_i = 1'b0;
        end
        if (pix_q.size() > 0) begin
            p = pix_q[0];
            bus.pix_dat_i  = p.dat;
            bus.pix_last_i = p.last;
            bus.pix_vld_i  = !gap || ($urandom_range(0, 2) != 0);
        end else begin
            bus.pix_vld_i = 1'b0;
        end
        @(negedge clk);
        sample();
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        bit fin = 1'b0;
        for (int unsigned n = 0; n < budget && !fin; n++) begin
            cycle();
            fin = (exp_q.size() == 0) && (req_q.size() == 0) && !busy;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got %0d beats still pending expected 0 within %0d cycles",
                     name, exp_q.size(), budget);
        end
    endtask

    // Expand a command into source items and the beat sequence the PHY should see
    task automatic start_vec(input vec_t v);
        logic [7:0] b;
        req_q.push_back('{hrst: v.hrst, typ: v.typ, pix: v.pix, num: v.num});
        if (v.hrst) begin
            exp_q.push_back('{hrst: 1'b1, typ: 8'h00, dat: 8'h00, no_dat: 1'b0, last: 1'b0});
        end else if (v.pix) begin
            for (int i = 0; i < int'(v.npix); i++) begin
                pix_q.push_back('{last: (i == int'(v.npix) - 1), dat: v.data[i]});
                exp_q.push_back('{hrst: 1'b0, typ: v.typ, dat: v.data[i][15:8], no_dat: 1'b0, last: 1'b0});
                exp_q.push_back('{hrst: 1'b0, typ: v.typ, dat: v.data[i][7:0], no_dat: 1'b0,
                                  last: (i == int'(v.npix) - 1)});
            end
        end else if (v.num == 4'd0) begin
            exp_q.push_back('{hrst: 1'b0, typ: v.typ, dat: 8'h00, no_dat: 1'b1, last: 1'b1});
        end else begin
            for (int i = 0; i < int'(v.num); i++) begin
                b = (i < 4) ? v.data[i][7:0] : 8'(8'hA0 + i);
                prm_q.push_back(b);
                exp_q.push_back('{hrst: 1'b0, typ: v.typ, dat: b, no_dat: 1'b0, last: (i == int'(v.num) - 1)});
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int b0 = beat_cnt;
        int p0 = pix_cnt;
        int d0 = done_cnt;
        start_vec(v);
        wait_done($sformatf("vec%0d", idx), 400);
        chk($sformatf("beats[%0d]", idx), beat_cnt - b0, {24'd0, v.exp_beats});
        chk($sformatf("pix_rdy[%0d]", idx), pix_cnt - p0, {24'd0, v.exp_pix});
        chk($sformatf("frm_done[%0d]", idx), done_cnt - d0, {24'd0, v.exp_done});
        chk($sformatf("src_left[%0d]", idx), prm_q.size() + pix_q.size(), 32'd0);
    endtask

    function automatic vec_t mk(input logic hrst, input logic [7:0] typ, input logic pix, input logic [3:0] num,
                                input int npix, input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input int beats, input int pixn, input int done);
        vec_t v;
        v.hrst = hrst;  v.typ = typ;  v.pix = pix;  v.num = num;  v.npix = 8'(npix);
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.exp_beats = 8'(beats); v.exp_pix = 8'(pixn); v.exp_done = 8'(done);
        return v;
    endfunction

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{hrst: 1'b1, typ: 8'h00, dat: 8'h00, no_dat: 1'b0, last: 1'b0});
        @(negedge clk);
        sample();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vld"},      {31'd0, bus.dtf_tx_vld_o}, 32'd0);
        chk({tag, "_hrst"},     {31'd0, bus.dtf_dbi_hrst_o}, 32'd0);
        chk({tag, "_rdys"},     {29'd0, bus.req_rdy_o, bus.prm_rdy_o, bus.pix_rdy_o}, 32'd0);
        chk({tag, "_busy"},     {30'd0, busy, frm_done}, 32'd0);
        chk({tag, "_typ"},      {24'd0, bus.dtf_tx_cmd_typ_o}, 32'd0);
        chk({tag, "_lastnd"},   {30'd0, bus.dtf_tx_last_o, bus.dtf_tx_no_dat_o}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        vecs[0] = mk(1'b0, OP_DISPON, 1'b0, 4'd0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[1] = mk(1'b0, OP_CASET,  1'b0, 4'd4,  0, 16'h0000, 16'h0000, 16'h0000, 16'h00EF, 4, 0, 0);
        vecs[2] = mk(1'b0, OP_RAMWR,  1'b1, 4'd0,  3, 16'hF800, 16'h07E0, 16'h001F, 16'h0000, 6, 3, 1);
        vecs[3] = mk(1'b0, OP_SLPOUT, 1'b0, 4'd0,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[4] = mk(1'b0, OP_PASET,  1'b0, 4'd1,  0, 16'h005A, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[5] = mk(1'b1, 8'h3C,     1'b0, 4'd3,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[6] = mk(1'b0, OP_RAMWR,  1'b1, 4'd7,  1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 2, 1, 1);
        vecs[7] = mk(1'b0, OP_CASET,  1'b0, 4'd15, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 15, 0, 0);
        vecs[8] = mk(1'b0, OP_RAMWR,  1'b1, 4'd0,  4, 16'hABCD, 16'h0102, 16'hFFFF, 16'h8001, 8, 4, 1);

        rst_n = 1'b0;
        bus.req_vld_i = 1'b0;  bus.req_hrst_i = 1'b0;  bus.req_typ_i = '0;
        bus.req_pix_i = 1'b0;  bus.req_prm_num_i = '0;
        bus.prm_vld_i = 1'b0;  bus.prm_dat_i = '0;
        bus.pix_vld_i = 1'b0;  bus.pix_dat_i = '0;  bus.pix_last_i = 1'b0;
        bus.dtf_tx_rdy_i = 1'b1;

        repeat (3) cycle();
        chk_reset_outputs("por");

        release_rst();
        cycle();
        chk("auto_hrst", {30'd0, bus.dtf_tx_vld_o, bus.dtf_dbi_hrst_o}, 32'd3);
        cycle();
        chk("req_rdy_after_hrst", {31'd0, bus.req_rdy_o}, 32'd1);

        for (int pass = 0; pass < 2; pass++) begin
            gap = (pass == 1);
            for (int i = 0; i < 9; i++) run_vec(vecs[i], pass * 10 + i);
        end
        gap = 1'b0;

        // Parameter/pixel data offered with no command must be left alone
        prm_q.push_back(8'h77);
        pix_q.push_back('{last: 1'b1, dat: 16'hBEEF});
        b0 = beat_cnt;
        repeat (6) cycle();
        chk("stray_kept", {16'd0, 8'(prm_q.size()), 8'(pix_q.size())}, 32'h0101);
        chk("stray_no_beat", beat_cnt - b0, 32'd0);
        prm_q.delete();
        pix_q.delete();
        cycle();

        // Abort a frame part way through and check the next frame is clean
        b0 = beat_cnt;
        start_vec(vecs[8]);
        for (int n = 0; n < 50 && beat_cnt < b0 + 3; n++) cycle();
        chk("mid_beats_seen", {31'd0, beat_cnt >= b0 + 3}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        exp_q.delete();
        req_q.delete();
        prm_q.delete();
        pix_q.delete();
        req_take = 1'b0;
        prm_take = 1'b0;
        pix_take = 1'b0;
        repeat (2) cycle();
        release_rst();
        wait_done("post_rst_hrst", 50);
        run_vec(vecs[2], 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
